// File: rtl/pio_pkg.sv
// Shared constants for the PIO state-machine FIFO slice: sticky flag bit
// positions and the width of the occupancy counters.
package pio_pkg;
  localparam int FLAG_W       = 4;
  localparam int FLAG_TXSTALL = 0;
  localparam int FLAG_TXOVER  = 1;
  localparam int FLAG_RXSTALL = 2;
  localparam int FLAG_RXUNDER = 3;
  localparam int LEVEL_W      = 4;
endpackage

// File: rtl/sm_fifo_core.sv
// Single FWFT FIFO with 2*DEPTH slots and a runtime capacity (0, DEPTH or 2*DEPTH).
// A capacity of 0 reads as both empty and full, which disables the direction.
module fifo_core
  import pio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic [LEVEL_W-1:0] cap,
  input  logic               wr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               rd,
  output logic [WIDTH-1:0]   head,
  output logic [LEVEL_W-1:0] level,
  output logic               empty,
  output logic               full
);
  localparam int SLOTS = 2 * DEPTH;
  localparam int AW    = $clog2(SLOTS);

  logic [WIDTH-1:0]   mem_q [SLOTS];
  logic [WIDTH-1:0]   mem_d [SLOTS];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [AW-1:0]      ptr_mask_s;
  logic               rd_ok_s, wr_ok_s;

  // Capacity is a power of two, so wrapping is a mask of cap-1.
  assign ptr_mask_s = AW'(cap - LEVEL_W'(1));
  assign empty      = (level_q == LEVEL_W'(0));
  assign full       = (level_q == cap);
  assign level      = level_q;
  assign head       = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  always_comb begin
    rd_ok_s  = rd & ~empty & ~clr;
    wr_ok_s  = wr & (~full | rd_ok_s) & ~clr;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LEVEL_W'(wr_ok_s) - LEVEL_W'(rd_ok_s);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok_s) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = (wr_ptr_q + AW'(1)) & ptr_mask_s;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok_s) begin
        rd_ptr_d = (rd_ptr_q + AW'(1)) & ptr_mask_s;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/sm_fifo.sv
// TX/RX FIFO pair between the bus and one PIO state machine, with optional
// join into a single double-depth FIFO and sticky stall/over/under flags.
module sm_fifo
  import pio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sm_tick,
  input  logic               flush,
  input  logic               join_tx,
  input  logic               join_rx,
  input  logic               tx_wr,
  input  logic [WIDTH-1:0]   tx_wdata,
  input  logic               sm_pull,
  output logic [WIDTH-1:0]   sm_din,
  output logic               tx_empty,
  output logic               tx_full,
  input  logic               sm_push,
  input  logic [WIDTH-1:0]   sm_dout,
  output logic               rx_full,
  output logic               rx_empty,
  input  logic               rx_rd,
  output logic [WIDTH-1:0]   rx_rdata,
  output logic [LEVEL_W-1:0] tx_level,
  output logic [LEVEL_W-1:0] rx_level,
  output logic [FLAG_W-1:0]  flags,
  input  logic [FLAG_W-1:0]  flags_clr
);
  localparam logic [LEVEL_W-1:0] CAP_ONE = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] CAP_TWO = LEVEL_W'(2 * DEPTH);

  logic               join_tx_q, join_tx_d, join_rx_q, join_rx_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic [FLAG_W-1:0]  flag_set_s;
  logic [LEVEL_W-1:0] tx_cap_s, rx_cap_s;
  logic               clr_s, tx_pop_s, rx_push_s;

  always_comb begin
    join_tx_d = join_tx;
    join_rx_d = join_rx;
    clr_s     = flush | (join_tx != join_tx_q) | (join_rx != join_rx_q);
    tx_pop_s  = sm_pull & sm_tick;
    rx_push_s = sm_push & sm_tick;
    if (join_tx_q) begin
      tx_cap_s = CAP_TWO;
      rx_cap_s = LEVEL_W'(0);
    end else if (join_rx_q) begin
      tx_cap_s = LEVEL_W'(0);
      rx_cap_s = CAP_TWO;
    end else begin
      tx_cap_s = CAP_ONE;
      rx_cap_s = CAP_ONE;
    end
    // Flag events mirror the drop rules inside fifo_core; a clearing cycle raises none.
    flag_set_s               = '0;
    flag_set_s[FLAG_TXSTALL] = tx_pop_s & tx_empty;
    flag_set_s[FLAG_TXOVER]  = tx_wr & tx_full & ~(tx_pop_s & ~tx_empty);
    flag_set_s[FLAG_RXSTALL] = rx_push_s & rx_full & ~(rx_rd & ~rx_empty);
    flag_set_s[FLAG_RXUNDER] = rx_rd & rx_empty;
    if (clr_s) begin
      flag_set_s = '0;
    end else begin
      flag_set_s = flag_set_s;
    end
    flags_d = (flags_q & ~flags_clr) | flag_set_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      join_tx_q <= 1'b0;
      join_rx_q <= 1'b0;
      flags_q   <= '0;
    end else begin
      join_tx_q <= join_tx_d;
      join_rx_q <= join_rx_d;
      flags_q   <= flags_d;
    end
  end

  assign flags = flags_q;

  fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .reset(reset), .clr(clr_s), .cap(tx_cap_s),
    .wr(tx_wr), .wdata(tx_wdata), .rd(tx_pop_s),
    .head(sm_din), .level(tx_level), .empty(tx_empty), .full(tx_full)
  );

  fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .reset(reset), .clr(clr_s), .cap(rx_cap_s),
    .wr(rx_push_s), .wdata(sm_dout), .rd(rx_rd),
    .head(rx_rdata), .level(rx_level), .empty(rx_empty), .full(rx_full)
  );
endmodule
